// File: rtl/imem_pkg.sv
// Shared types and defaults for the loadable instruction memory.
package imem_pkg;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

  localparam logic [31:0] IMEM_FILL_DEFAULT  = 32'hAC11_0000;
  localparam int          IMEM_DEPTH_DEFAULT = 256;

  // Word-address width for a given depth; never narrower than one bit.
  function automatic int imem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Single-port word RAM: synchronous write, combinational read.
module imem_word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: program contents survive reset and load restarts.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: LOAD/RUN FSM, load counter, registered fetch port.
// Optional misaligned-fetch trap enabled by defining IMEM_MISALIGN_TRAP_EN.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = IMEM_DEPTH_DEFAULT,
  parameter int               PC_LIMIT   = DEPTH * 4,
  parameter logic [WIDTH-1:0] FILL_INSTR = WIDTH'(IMEM_FILL_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      ld_valid,
  input  logic [WIDTH-1:0]          ld_data,
  input  logic                      ld_last,
  output logic                      ld_ready,
  output logic [imem_aw(DEPTH):0]   ld_count,
  input  logic                      fetch_req,
  input  logic [WIDTH-1:0]          PC,
  output logic [WIDTH-1:0]          RD,
  output logic                      rd_valid,
  output logic                      busy,
  output imem_state_e               state
`ifdef IMEM_MISALIGN_TRAP_EN
  ,
  output logic                      misalign
`endif
);

  localparam int               AW       = imem_aw(DEPTH);
  localparam logic [AW:0]      LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_LIM   = WIDTH'(PC_LIMIT);

  // Load handshake: a word transfers on a rising edge where ld_valid and
  // ld_ready are both high; ld_data/ld_last are qualified by ld_valid.
  // load_start on the same edge wins and the offered word is dropped.
  imem_state_e      state_q, state_d;
  logic             accept, we, fetch_go, fill;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] ram_rdata, fetch_word;

  assign ld_ready = (state_q == IMEM_LOAD);
  assign busy     = (state_q == IMEM_LOAD);
  assign state    = state_q;
  assign accept   = ld_valid & ld_ready;
  assign we       = accept & ~load_start;
  assign fetch_go = fetch_req & (state_q == IMEM_RUN) & ~load_start;
  assign idx      = PC[AW+1:2];

  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = IMEM_LOAD;
    end else if (accept && (ld_last || ld_count == LAST_IDX)) begin
      state_d = IMEM_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IMEM_LOAD;
      ld_count <= '0;
    end else begin
      state_q <= state_d;
      if (load_start)  ld_count <= '0;
      else if (accept) ld_count <= ld_count + (AW+1)'(1);
    end
  end

  imem_word_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ld_count[AW-1:0]),
    .wdata (ld_data),
    .raddr (idx),
    .rdata (ram_rdata)
  );

`ifdef IMEM_MISALIGN_TRAP_EN
  logic mis_bad;
  assign mis_bad = (PC[1:0] != 2'b00);
  assign fill    = (PC >= PC_LIM) || ({1'b0, idx} >= DEPTH_W) || mis_bad;

  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= fetch_go & mis_bad;
  end
`else
  assign fill = (PC >= PC_LIM) || ({1'b0, idx} >= DEPTH_W);
`endif

  assign fetch_word = fill ? FILL_INSTR : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      RD       <= FILL_INSTR;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fetch_go;
      if (fetch_go) RD <= fetch_word;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: load, fetch, range, reset and collision cases.
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] FILL  = 32'hAC11_0000;

  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0;
  logic ld_valid = 1'b0, ld_last = 1'b0, fetch_req = 1'b0;
  logic [31:0] ld_data = '0, PC = '0;
  logic ld_ready, rd_valid, busy;
  logic [AW:0] ld_count;
  logic [31:0] RD;
  imem_state_e state;
`ifdef IMEM_MISALIGN_TRAP_EN
  logic misalign;
`endif

  logic [31:0] model_mem [DEPTH];
  int          model_cnt = 0;
  logic [31:0] last_exp  = FILL;
  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];
  logic [31:0] ld_buf[$];
  int          tests_run = 0, tests_failed = 0;

  logic [31:0] fact_prog [9] = '{32'h00008020, 32'h20100007, 32'h20110001,
                                 32'h12000004, 32'h00000000, 32'h0230881C,
                                 32'h2210FFFF, 32'h08000003, 32'hAC110000};

  imem_loadable dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count),
    .fetch_req(fetch_req), .PC(PC), .RD(RD), .rd_valid(rd_valid),
    .busy(busy), .state(state)
`ifdef IMEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        em;
    if (rd_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rd_valid RD=%h expected no output", RD);
      end else begin
        e  = exp_q.pop_front();
        em = exp_mis_q.pop_front();
        if (RD !== e) begin
          tests_failed++;
          $display("FAIL rd_data got=%h exp=%h", RD, e);
        end
`ifdef IMEM_MISALIGN_TRAP_EN
        if (misalign !== em) begin
          tests_failed++;
          $display("FAIL misalign_flag got=%b exp=%b", misalign, em);
        end
`else
        if (em !== 1'b0) $display("note: unexpected misalign expectation");
`endif
      end
    end
`ifdef IMEM_MISALIGN_TRAP_EN
    else if (misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_idle got=%b exp=0", misalign);
    end
`endif
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    if (pc >= 32'h400) return FILL;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (pc[1:0] != 2'b00) return FILL;
`endif
    return model_mem[pc[9:2]];
  endfunction

  task automatic load_buf(input bit with_last);
    for (int i = 0; i < ld_buf.size(); i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = ld_buf[i];
      ld_last  = with_last && (i == ld_buf.size() - 1);
      model_mem[model_cnt % DEPTH] = ld_buf[i];
      model_cnt++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    @(negedge clk);
    fetch_req = 1'b1;
    PC        = pc;
    last_exp  = exp_word(pc);
    exp_q.push_back(last_exp);
`ifdef IMEM_MISALIGN_TRAP_EN
    exp_mis_q.push_back(pc[1:0] != 2'b00);
`else
    exp_mis_q.push_back(1'b0);
`endif
  endtask

  task automatic idle();
    @(negedge clk);
    fetch_req  = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic pulse_load_start();
    @(negedge clk);
    load_start = 1'b1;
    model_cnt  = 0;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 6;
    if (RD !== FILL) begin tests_failed++; $display("FAIL reset_rd got=%h exp=%h", RD, FILL); end
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (ld_count !== '0) begin tests_failed++; $display("FAIL reset_ld_count got=%0d exp=0", ld_count); end
    if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy got=%b exp=1", busy); end
    if (state !== IMEM_LOAD) begin tests_failed++; $display("FAIL reset_state got=%0d exp=LOAD", state); end
`ifdef IMEM_MISALIGN_TRAP_EN
    tests_run++;
    if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
`endif
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_full_load();
    ld_buf.delete();
    for (int i = 0; i < DEPTH; i++) ld_buf.push_back($urandom());
    load_buf(1'b0);
    tests_run += 4;
    if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ld_ready got=%b exp=0", ld_ready); end
    if (ld_count !== 9'd256) begin tests_failed++; $display("FAIL full_ld_count got=%0d exp=256", ld_count); end
    if (state !== IMEM_RUN) begin tests_failed++; $display("FAIL full_state got=%0d exp=RUN", state); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy got=%b exp=0", busy); end
    // A 257th word must not be taken (it would overwrite word 0).
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = ~model_mem[0];
    @(negedge clk);
    ld_valid = 1'b0;
    tests_run++;
    if (ld_count !== 9'd256) begin tests_failed++; $display("FAIL extra_word_count got=%0d exp=256", ld_count); end
    fetch(32'h0);
    idle();
  endtask

  task automatic test_out_of_range();
    fetch(32'h400);
    fetch(32'h3FC);
    fetch(32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) fetch({22'd0, 8'($urandom_range(0, 255)), 2'b00});
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_factorial();
    pulse_load_start();
    tests_run += 2;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL restart_busy got=%b exp=1", busy); end
    if (ld_count !== '0) begin tests_failed++; $display("FAIL restart_count got=%0d exp=0", ld_count); end
    ld_buf.delete();
    for (int i = 0; i < 9; i++) ld_buf.push_back(fact_prog[i]);
    load_buf(1'b1);
    tests_run += 2;
    if (ld_count !== 9'd9) begin tests_failed++; $display("FAIL fact_count got=%0d exp=9", ld_count); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL fact_busy got=%b exp=0", busy); end
    fetch(32'h14);
    idle();
    tests_run += 2;
    if (RD !== 32'h0230881C) begin tests_failed++; $display("FAIL fact_word5 got=%h exp=0230881c", RD); end
    if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL fact_valid got=%b exp=1", rd_valid); end
  endtask

  task automatic test_misalign();
    fetch(32'h6);
    idle();
    tests_run++;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (RD !== FILL) begin tests_failed++; $display("FAIL misalign_rd got=%h exp=%h", RD, FILL); end
    tests_run++;
    if (misalign !== 1'b1) begin tests_failed++; $display("FAIL misalign_pulse got=%b exp=1", misalign); end
`else
    if (RD !== 32'h20100007) begin tests_failed++; $display("FAIL unaligned_rd got=%h exp=20100007", RD); end
`endif
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL misalign_single got=%b exp=0", rd_valid); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    load_start = 1'b1;
    fetch_req  = 1'b1;
    PC         = 32'h0;
    model_cnt  = 0;
    idle();
    tests_run += 4;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_valid got=%b exp=0", rd_valid); end
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL collide_busy got=%b exp=1", busy); end
    if (ld_count !== '0) begin tests_failed++; $display("FAIL collide_count got=%0d exp=0", ld_count); end
    if (RD !== last_exp) begin tests_failed++; $display("FAIL collide_rd_hold got=%h exp=%h", RD, last_exp); end
    // Fetch while loading is dropped and RD holds.
    @(negedge clk);
    fetch_req = 1'b1;
    PC = 32'h4;
    idle();
    tests_run += 2;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL load_fetch_valid got=%b exp=0", rd_valid); end
    if (RD !== last_exp) begin tests_failed++; $display("FAIL load_fetch_hold got=%h exp=%h", RD, last_exp); end
  endtask

  task automatic test_back_to_back();
    ld_buf.delete();
    for (int i = 0; i < 9; i++) ld_buf.push_back(fact_prog[i]);
    load_buf(1'b1);
    fetch(32'h0);
    fetch(32'h4);
    tests_run++;
    if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid0 got=%b exp=1", rd_valid); end
    fetch(32'h8);
    tests_run++;
    if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid1 got=%b exp=1", rd_valid); end
    idle();
    tests_run++;
    if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid2 got=%b exp=1", rd_valid); end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got=%b exp=0", rd_valid); end
  endtask

  task automatic test_reset_mid_load();
    // Reset on the same edge as a fetch cancels the pending rd_valid.
    @(negedge clk);
    fetch_req = 1'b1;
    PC        = 32'h0;
    rst       = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    rst       = 1'b0;
    model_cnt = 0;
    last_exp  = FILL;
    tests_run += 3;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_fetch_valid got=%b exp=0", rd_valid); end
    if (RD !== FILL) begin tests_failed++; $display("FAIL rst_fetch_rd got=%h exp=%h", RD, FILL); end
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_fetch_busy got=%b exp=1", busy); end
    ld_buf.delete();
    for (int i = 0; i < 3; i++) ld_buf.push_back($urandom());
    load_buf(1'b0);
    tests_run++;
    if (ld_count !== 9'd3) begin tests_failed++; $display("FAIL midload_count got=%0d exp=3", ld_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    tests_run += 2;
    if (ld_count !== '0) begin tests_failed++; $display("FAIL midrst_count got=%0d exp=0", ld_count); end
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    ld_buf.delete();
    for (int i = 0; i < 2; i++) ld_buf.push_back($urandom());
    load_buf(1'b1);
    fetch(32'h8);
    fetch(32'h0);
    fetch(32'h4);
    idle();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_out_of_range();
    test_factorial();
    test_misalign();
    test_collision();
    test_back_to_back();
    test_reset_mid_load();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout outstanding=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
